token_encoder: RTL and testbench
================================

# token_encoder

Parametrised word-to-token encoder for the tensor_core front end. On `start` it walks a zero-separated character string in an external input memory and looks up each word in a fixed-slot vocabulary memory. For every non-empty word it writes one token index to an output memory, or the unknown token if no vocabulary entry matches. It supersedes the fixed 16-entry encoder with configurable vocabulary size, word length and text length, explicit unknown-word handling, and status counters.

## Interface
- `DATA_WIDTH`, 8: character width.
- `ADDR_WIDTH`, 8: input/output memory address width; max text length 2^ADDR_WIDTH-1.
- `VOCAB_ENTRIES`, 16: number of vocabulary slots.
- `MAX_WORD_LEN`, 4: characters per vocab slot, zero-padded.
- `TOKEN_WIDTH`, $clog2(VOCAB_ENTRIES)+1: token width; UNK token = all ones.
- `VADDR_WIDTH`, $clog2(VOCAB_ENTRIES*MAX_WORD_LEN): vocab address width.
- `clk` in 1: clock, all logic on rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE/DONE.
- `in_len` in ADDR_WIDTH: text length in characters, sampled with `start`.
- `in_addr` out ADDR_WIDTH: input memory read address.
- `in_data` in DATA_WIDTH: input memory data, valid one cycle after `in_addr` (synchronous read).
- `voc_addr` out VADDR_WIDTH: vocab read address, slot v char k at v*MAX_WORD_LEN+k.
- `voc_data` in DATA_WIDTH: vocab data, one-cycle read latency.
- `out_we` out 1: output write strobe, one cycle per token.
- `out_addr` out ADDR_WIDTH: output token address, 0,1,2,...
- `out_data` out TOKEN_WIDTH: token value.
- `busy` out 1: high from the cycle after accepted `start` until DONE.
- `done` out 1: level, high in DONE until next accepted `start`.
- `token_count` out ADDR_WIDTH: tokens written this run.
- `unk_count` out ADDR_WIDTH: UNK tokens written this run.

## Operation
- States: IDLE, SCAN_A, SCAN_D, CMP_A, CMP_D, WRITE, DONE.
- `start` in IDLE/DONE: latch `in_len`; clear ws (word start), wlen, token_count, unk_count, out pointer; `done`<=0; go to SCAN_A. `start` while `busy` is ignored.
- SCAN_A: if ws+wlen == in_len, treat as end-of-word. Otherwise drive `in_addr`=ws+wlen and go to SCAN_D.
- SCAN_D: `in_data`==0 is end-of-word; else wlen++ and go back to SCAN_A.
- End-of-word handling:
  - wlen==0: empty word (leading or consecutive separator); ws++, emit no token.
  - wlen>MAX_WORD_LEN: token=UNK, go to WRITE.
  - otherwise: v=0, k=0, go to CMP_A.
- CMP_A: drive `voc_addr`=v*MAX_WORD_LEN+k and `in_addr`=ws+k; go to CMP_D.
- CMP_D: expected char = `in_data` if k<wlen, else 0.
  - Mismatch with `voc_data`: v++, k=0.
  - Match with k==MAX_WORD_LEN-1: hit, token=v, go to WRITE.
  - Match otherwise: k++, back to CMP_A.
  - v reaching VOCAB_ENTRIES: token=UNK, go to WRITE.
- First matching slot (lowest index) wins.
- WRITE: `out_we`=1, `out_addr`=token_count, `out_data`=token; token_count++; unk_count++ if UNK; ws=ws+wlen+1, wlen=0.
- After an empty word or WRITE: go to DONE if ws>=in_len, else SCAN_A.
- A trailing separator does not create a token. `in_len`=0 goes straight to DONE.
- Reset values: state IDLE, `busy`=0, `done`=0, `out_we`=0, all addresses/`out_data`/counters 0.

## Timing
- Memory reads are 1-cycle latency: address in *_A state, data consumed in *_D state.
- Scan costs 2 cycles per character plus 1 cycle (SCAN_A) at end of word.
- Compare costs 2 cycles per compared character.
- WRITE is 1 cycle; `out_we` is high only in WRITE.
- DONE is entered the cycle after the last WRITE or skip: `done`=1, `busy`=0.
- `token_count`/`unk_count` stay stable in DONE.
- `rst_n` low at any time: immediate return to reset values; no partial write completes. The outputs already written remain in the memory.
- ws+wlen arithmetic is ADDR_WIDTH+1 bits wide; no wrap.

## Test plan
- Vocab {0:"a",1:"cat",2:"dog"}, rest zero; text "cat\0a\0dog", in_len=9 -> writes 1,0,2 at out 0..2; token_count=3, unk_count=0; done=1.
- Text "cow", in_len=3 -> one write of 31 (UNK, TOKEN_WIDTH=5); unk_count=1.
- Text "catsx\0a", in_len=7 -> 31 then 0; the long word needs no vocab reads (voc_addr untouched before the first token).
- Text "\0\0dog\0", in_len=6 -> single token 2; empty words skipped; token_count=1.
- Duplicate "dog" in slots 2 and 5 -> token 2. in_len=0 -> done next cycle-pair, token_count=0, no out_we.
- rst_n asserted mid-compare of the second word -> outputs reset immediately. A new start re-encodes from out_addr 0 with correct results.

Source files
------------

// File: rtl/token_encoder.sv
// token_encoder
//
// Walks a zero-separated character string held in an external input memory.
// Each non-empty word is looked up in a fixed-slot vocabulary memory. Every
// word produces one token index in an output memory: the index of the lowest
// matching slot, or the UNK token (all ones) when no slot matches.
// Both memories are synchronous-read with one cycle of latency. An address is
// driven in an *_A state and the returned data is consumed in the matching
// *_D state.
//
// Ports
//   clk, rst_n    : rising-edge clock, asynchronous active-low reset
//   start, in_len : one-cycle run request and text length (sampled together)
//   in_addr       : input memory read address
//   in_data       : input memory read data
//   voc_addr      : vocabulary read address (slot v, char k at v*MAX_WORD_LEN+k)
//   voc_data      : vocabulary read data
//   out_we        : output memory write strobe, one cycle per token
//   out_addr      : output memory write address
//   out_data      : output memory write data (the token)
//   busy          : high while a run is in progress
//   done          : high after a run completes, until the next accepted start
//   token_count   : number of tokens written in this run
//   unk_count     : number of UNK tokens written in this run
module token_encoder #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 8,
    parameter int VOCAB_ENTRIES = 16,
    parameter int MAX_WORD_LEN  = 4,
    parameter int TOKEN_WIDTH   = $clog2(VOCAB_ENTRIES) + 1,
    parameter int VADDR_WIDTH   = $clog2(VOCAB_ENTRIES * MAX_WORD_LEN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  in_len,
    output logic [ADDR_WIDTH-1:0]  in_addr,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic [VADDR_WIDTH-1:0] voc_addr,
    input  logic [DATA_WIDTH-1:0]  voc_data,
    output logic                   out_we,
    output logic [ADDR_WIDTH-1:0]  out_addr,
    output logic [TOKEN_WIDTH-1:0] out_data,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  token_count,
    output logic [ADDR_WIDTH-1:0]  unk_count
);

    // The text position is one bit wider than the address, so that
    // ws + wlen + 1 can step past the last character without wrapping.
    localparam int PW = ADDR_WIDTH + 1;
    localparam int KW = $clog2(MAX_WORD_LEN) + 1;
    localparam int VW = TOKEN_WIDTH;

    localparam logic [TOKEN_WIDTH-1:0] UNK    = '1;
    localparam logic [PW-1:0]          MWL_P  = PW'(MAX_WORD_LEN);
    localparam logic [KW-1:0]          K_LAST = KW'(MAX_WORD_LEN - 1);
    localparam logic [VW-1:0]          V_LAST = VW'(VOCAB_ENTRIES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SCAN_A = 3'd1,
        SCAN_D = 3'd2,
        CMP_A  = 3'd3,
        CMP_D  = 3'd4,
        WRITE  = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  len_q, len_d;
    logic [PW-1:0]          ws_q, ws_d;
    logic [PW-1:0]          wlen_q, wlen_d;
    logic [VW-1:0]          v_q, v_d;
    logic [KW-1:0]          k_q, k_d;
    logic [TOKEN_WIDTH-1:0] token_q, token_d;
    logic [ADDR_WIDTH-1:0]  tcnt_q, tcnt_d;
    logic [ADDR_WIDTH-1:0]  ucnt_q, ucnt_d;
    logic [ADDR_WIDTH-1:0]  in_addr_q;
    logic [VADDR_WIDTH-1:0] voc_addr_q;

    logic [PW-1:0]          scan_pos;
    logic [PW-1:0]          len_ext;
    logic [DATA_WIDTH-1:0]  exp_char;
    logic                   end_word;

    assign scan_pos = ws_q + wlen_q;
    assign len_ext  = {1'b0, len_q};
    // Vocabulary slots are zero-padded, so the character positions past the
    // end of the word must compare against zero.
    assign exp_char = (PW'(k_q) < wlen_q) ? in_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            ws_q       <= '0;
            wlen_q     <= '0;
            v_q        <= '0;
            k_q        <= '0;
            token_q    <= '0;
            tcnt_q     <= '0;
            ucnt_q     <= '0;
            in_addr_q  <= '0;
            voc_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            ws_q       <= ws_d;
            wlen_q     <= wlen_d;
            v_q        <= v_d;
            k_q        <= k_d;
            token_q    <= token_d;
            tcnt_q     <= tcnt_d;
            ucnt_q     <= ucnt_d;
            in_addr_q  <= in_addr;
            voc_addr_q <= voc_addr;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        ws_d     = ws_q;
        wlen_d   = wlen_q;
        v_d      = v_q;
        k_d      = k_q;
        token_d  = token_q;
        tcnt_d   = tcnt_q;
        ucnt_d   = ucnt_q;
        // Read addresses hold their last driven value outside the *_A states.
        in_addr  = in_addr_q;
        voc_addr = voc_addr_q;
        out_we   = 1'b0;
        end_word = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    len_d   = in_len;
                    ws_d    = '0;
                    wlen_d  = '0;
                    tcnt_d  = '0;
                    ucnt_d  = '0;
                    state_d = SCAN_A;
                end
            end
            SCAN_A: begin
                if (scan_pos == len_ext) begin
                    end_word = 1'b1;
                end else begin
                    in_addr = scan_pos[ADDR_WIDTH-1:0];
                    state_d = SCAN_D;
                end
            end
            SCAN_D: begin
                if (in_data == '0) begin
                    end_word = 1'b1;
                end else begin
                    wlen_d  = wlen_q + 1'b1;
                    state_d = SCAN_A;
                end
            end
            CMP_A: begin
                voc_addr = VADDR_WIDTH'(v_q) * VADDR_WIDTH'(MAX_WORD_LEN)
                         + VADDR_WIDTH'(k_q);
                in_addr  = ADDR_WIDTH'(ws_q + PW'(k_q));
                state_d  = CMP_D;
            end
            CMP_D: begin
                if (exp_char != voc_data) begin
                    if (v_q == V_LAST) begin
                        token_d = UNK;
                        state_d = WRITE;
                    end else begin
                        v_d     = v_q + 1'b1;
                        k_d     = '0;
                        state_d = CMP_A;
                    end
                end else if (k_q == K_LAST) begin
                    token_d = v_q;
                    state_d = WRITE;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = CMP_A;
                end
            end
            WRITE: begin
                out_we = 1'b1;
                tcnt_d = tcnt_q + 1'b1;
                if (token_q == UNK) begin
                    ucnt_d = ucnt_q + 1'b1;
                end
                // Skip the word and the separator that follows it.
                ws_d    = scan_pos + 1'b1;
                wlen_d  = '0;
                state_d = ((scan_pos + 1'b1) >= len_ext) ? DONE : SCAN_A;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (end_word) begin
            if (wlen_q == '0) begin
                // Leading, trailing or repeated separator: no token.
                ws_d    = ws_q + 1'b1;
                state_d = ((ws_q + 1'b1) >= len_ext) ? DONE : SCAN_A;
            end else if (wlen_q > MWL_P) begin
                // A word longer than any slot can never match.
                token_d = UNK;
                state_d = WRITE;
            end else begin
                v_d     = '0;
                k_d     = '0;
                state_d = CMP_A;
            end
        end
    end

    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign done        = (state_q == DONE);
    assign out_addr    = tcnt_q;
    assign out_data    = token_q;
    assign token_count = tcnt_q;
    assign unk_count   = ucnt_q;

endmodule

// File: tb/tb_token_encoder.sv
// Self-checking bench for token_encoder: a reference model splits the text
// into words and looks each one up in the vocabulary, pushing the expected
// writes into a queue; a monitor pops the queue on every out_we.
module tb_token_encoder;

    localparam int DW  = 8;
    localparam int AW  = 8;
    localparam int VE  = 16;
    localparam int MWL = 4;
    localparam int TW  = $clog2(VE) + 1;
    localparam int VAW = $clog2(VE * MWL);
    localparam int UNK = (1 << TW) - 1;
    localparam int MAX_CYC = 20000;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic [AW-1:0]  in_len = '0;
    logic [AW-1:0]  in_addr;
    logic [DW-1:0]  in_data;
    logic [VAW-1:0] voc_addr;
    logic [DW-1:0]  voc_data;
    logic           out_we;
    logic [AW-1:0]  out_addr;
    logic [TW-1:0]  out_data;
    logic           busy;
    logic           done;
    logic [AW-1:0]  token_count;
    logic [AW-1:0]  unk_count;

    token_encoder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .VOCAB_ENTRIES(VE), .MAX_WORD_LEN(MWL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_len(in_len),
        .in_addr(in_addr), .in_data(in_data),
        .voc_addr(voc_addr), .voc_data(voc_data),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data),
        .busy(busy), .done(done),
        .token_count(token_count), .unk_count(unk_count)
    );

    always #5 clk = ~clk;

    logic [7:0] in_mem [256];
    logic [7:0] voc_mem [VE*MWL];

    always @(posedge clk) begin
        in_data  <= in_mem[in_addr];
        voc_data <= voc_mem[voc_addr];
    end

    typedef struct {
        int addr;
        int tok;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   passed = 0;
    int   exp_tok;
    int   exp_unk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n && out_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got token %0d at addr %0d, required no write",
                         out_data, out_addr);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_addr", 32'(out_addr), mon_e.addr);
                check("out_data", 32'(out_data), mon_e.tok);
            end
        end
    end

    // Reference model
    function automatic int lookup(input logic [7:0] w[$]);
        bit         hit;
        logic [7:0] c;
        if (w.size() > MWL) return UNK;
        for (int v = 0; v < VE; v++) begin
            hit = 1'b1;
            for (int k = 0; k < MWL; k++) begin
                c = (k < w.size()) ? w[k] : 8'h00;
                if (voc_mem[v*MWL+k] != c) hit = 1'b0;
            end
            if (hit) return v;
        end
        return UNK;
    endfunction

    task automatic model(input int len);
        logic [7:0] w[$];
        exp_t       e;
        exp_tok = 0;
        exp_unk = 0;
        for (int i = 0; i <= len; i++) begin
            if (i == len || in_mem[i] == 8'h00) begin
                if (w.size() > 0) begin
                    e.addr = exp_tok;
                    e.tok  = lookup(w);
                    exp_q.push_back(e);
                    exp_tok++;
                    if (e.tok == UNK) exp_unk++;
                end
                w.delete();
            end else begin
                w.push_back(in_mem[i]);
            end
        end
    endtask

    task automatic clear_vocab();
        foreach (voc_mem[i]) voc_mem[i] = 8'h00;
    endtask

    task automatic put_word(input int slot, input string s);
        for (int k = 0; k < MWL; k++)
            voc_mem[slot*MWL+k] = (k < s.len()) ? s[k] : 8'h00;
    endtask

    // '.' in the string stands for a zero separator; bytes past the text are
    // nonzero garbage.
    task automatic load_text(input string s);
        foreach (in_mem[i]) in_mem[i] = 8'($urandom_range(1, 255));
        for (int i = 0; i < s.len(); i++)
            in_mem[i] = (s[i] == 8'h2E) ? 8'h00 : s[i];
    endtask

    task automatic recover();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic run(input string name, input int len, output int cyc, output bit voc_moved);
        logic [VAW-1:0] voc0;
        bit             seen;
        model(len);
        @(negedge clk);
        start  = 1'b1;
        in_len = AW'(len);
        @(negedge clk);
        start  = 1'b0;
        check({name, "_busy_after_start"}, 32'(busy), 1);
        check({name, "_done_cleared"}, 32'(done), 0);
        voc0 = voc_addr;
        seen = 1'b0;
        voc_moved = 1'b0;
        cyc = 0;
        while (!done && cyc < MAX_CYC) begin
            if (out_we) seen = 1'b1;
            else if (!seen && voc_addr != voc0) voc_moved = 1'b1;
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            checks++;
            $display("FAIL %s_timeout: done not seen after %0d cycles", name, cyc);
            recover();
        end else begin
            check({name, "_token_count"}, 32'(token_count), exp_tok);
            check({name, "_unk_count"}, 32'(unk_count), exp_unk);
            check({name, "_busy_in_done"}, 32'(busy), 0);
            check({name, "_all_written"}, exp_q.size(), 0);
        end
    endtask

    int         cyc;
    bit         moved;
    int         len;
    int         wl;
    int         tc_hold;
    logic [7:0] ch;

    initial begin
        foreach (in_mem[i]) in_mem[i] = 8'h00;
        clear_vocab();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_out_we", 32'(out_we), 0);
        check("rst_out_addr", 32'(out_addr), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_token_count", 32'(token_count), 0);
        check("rst_in_addr", 32'(in_addr), 0);
        check("rst_voc_addr", 32'(voc_addr), 0);
        rst_n = 1'b1;
        @(negedge clk);

        put_word(0, "a");
        put_word(1, "cat");
        put_word(2, "dog");

        load_text("cat.a.dog");
        run("basic", 9, cyc, moved);
        tc_hold = 32'(token_count);
        repeat (3) @(negedge clk);
        check("basic_done_level", 32'(done), 1);
        check("basic_count_stable", 32'(token_count), tc_hold);
        check("basic_count_value", 32'(token_count), 3);

        load_text("cow");
        run("unk", 3, cyc, moved);
        check("unk_unk_count_value", 32'(unk_count), 1);

        load_text("catsx.a");
        run("longword", 7, cyc, moved);
        check("longword_no_voc_read", 32'(moved), 0);

        load_text("..dog.");
        run("empties", 6, cyc, moved);

        put_word(5, "dog");
        load_text("dog");
        run("duplicate", 3, cyc, moved);

        load_text("");
        run("len0", 0, cyc, moved);
        check("len0_latency", cyc, 1);
        check("len0_count", 32'(token_count), 0);

        load_text("a");
        run("single", 1, cyc, moved);
        check("single_latency", cyc, 12);

        // Reset in the middle of comparing the second word, then rerun.
        load_text("cat.a.dog");
        model(9);
        @(negedge clk);
        start  = 1'b1;
        in_len = 8'd9;
        @(negedge clk);
        start  = 1'b0;
        cyc = 0;
        while (!out_we && cyc < MAX_CYC) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_we) begin
            checks++;
            $display("FAIL midreset_timeout: first write not seen after %0d cycles", cyc);
        end
        repeat (6) @(negedge clk);
        check("midreset_busy_before", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midreset_busy", 32'(busy), 0);
        check("midreset_done", 32'(done), 0);
        check("midreset_out_we", 32'(out_we), 0);
        check("midreset_token_count", 32'(token_count), 0);
        check("midreset_unk_count", 32'(unk_count), 0);
        check("midreset_out_data", 32'(out_data), 0);
        check("midreset_voc_addr", 32'(voc_addr), 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run("restart", 9, cyc, moved);

        // Randomized runs over a three-letter alphabet
        for (int r = 0; r < 40; r++) begin
            clear_vocab();
            for (int v = 0; v < VE; v++) begin
                if ($urandom_range(0, 1) == 1) begin
                    wl = $urandom_range(1, MWL);
                    for (int k = 0; k < wl; k++)
                        voc_mem[v*MWL+k] = 8'h61 + 8'($urandom_range(0, 2));
                end
            end
            load_text("");
            len = $urandom_range(0, 40);
            for (int i = 0; i < len; i++) begin
                ch = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'h61 + 8'($urandom_range(0, 2));
                in_mem[i] = ch;
            end
            run("random", len, cyc, moved);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
